// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO write unit: ex_op encodings and the pending-entry layout.
package hilo_pkg;

    localparam logic [1:0] HILO_OP_NONE   = 2'd0;
    localparam logic [1:0] HILO_OP_MTLO   = 2'd1;
    localparam logic [1:0] HILO_OP_MTHI   = 2'd2;
    localparam logic [1:0] HILO_OP_MULDIV = 2'd3;

    localparam int PEND_W = 66;

    typedef struct packed {
        logic        we_hi;
        logic        we_lo;
        logic [31:0] hi_val;
        logic [31:0] lo_val;
    } pend_entry_t;

endpackage

// File: rtl/hilo_pend_fifo.sv
// Two-entry in-order buffer of speculative HI/LO writes, with a lookup of the
// youngest entry that writes the requested half (falls back to the arch value).
module hilo_pend_fifo
    import hilo_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  pend_entry_t push_entry,
    input  logic        lookup_hi,
    input  logic [31:0] arch_val,
    output pend_entry_t head,
    output logic [1:0]  count,
    output logic        sel_hit,
    output logic [31:0] sel_val
);

    logic [PEND_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    pend_entry_t       young;
    pend_entry_t       old;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head = pend_entry_t'(mem[rd_ptr]);

    // Youngest entry sits just behind wr_ptr; with two entries the older one shares wr_ptr's slot.
    assign young = pend_entry_t'(mem[~wr_ptr]);
    assign old   = pend_entry_t'(mem[wr_ptr]);

    always_comb begin
        sel_hit = 1'b0;
        sel_val = arch_val;
        if (count != 2'd0 && (lookup_hi ? young.we_hi : young.we_lo)) begin
            sel_hit = 1'b1;
            if (BYPASS) sel_val = lookup_hi ? young.hi_val : young.lo_val;
        end else if (count == 2'd2 && (lookup_hi ? old.we_hi : old.we_lo)) begin
            sel_hit = 1'b1;
            if (BYPASS) sel_val = lookup_hi ? old.hi_val : old.lo_val;
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: buffers EX-stage HI/LO writes until commit, discards them on flush.
// Build option HILO_BYPASS_EN forwards pending values to MFHI/MFLO; otherwise such reads stall.
module hilo_unit
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [1:0]  ex_op,
    input  logic        ex_done,
    input  logic [63:0] ex_result,
    input  logic [31:0] ex_src,
    output logic        ex_ready,
    input  logic        commit,
    input  logic        flush,
    input  logic        rd_req,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        rd_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  pend_cnt
);

`ifdef HILO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    pend_entry_t push_entry;
    pend_entry_t head;
    logic        push_kind;
    logic        push;
    logic        pop;
    logic        sel_hit;
    logic [31:0] sel_val;

    assign push_kind = (ex_op == HILO_OP_MTLO) || (ex_op == HILO_OP_MTHI) ||
                       (ex_op == HILO_OP_MULDIV && ex_done);
    assign ex_ready  = (pend_cnt != 2'd2) || commit;
    assign push      = ex_valid && ex_ready && !flush && push_kind;
    assign pop       = commit && (pend_cnt != 2'd0);

    always_comb begin
        push_entry = '0;
        case (ex_op)
            HILO_OP_MTLO:   push_entry = '{we_hi: 1'b0, we_lo: 1'b1, hi_val: ex_src, lo_val: ex_src};
            HILO_OP_MTHI:   push_entry = '{we_hi: 1'b1, we_lo: 1'b0, hi_val: ex_src, lo_val: ex_src};
            HILO_OP_MULDIV: push_entry = '{we_hi: 1'b1, we_lo: 1'b1,
                                           hi_val: ex_result[63:32], lo_val: ex_result[31:0]};
            default:        push_entry = '0;
        endcase
    end

    hilo_pend_fifo #(.BYPASS(BYPASS)) u_pend (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .lookup_hi  (rd_sel),
        .arch_val   (rd_sel ? hi : lo),
        .head       (head),
        .count      (pend_cnt),
        .sel_hit    (sel_hit),
        .sel_val    (sel_val)
    );

    // A commit under flush still retires the head; the FIFO drops the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (pop) begin
            if (head.we_hi) hi <= head.hi_val;
            if (head.we_lo) lo <= head.lo_val;
        end
    end

    assign rd_data  = sel_val;
    assign rd_stall = rd_req && sel_hit && !BYPASS;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: a queue-based reference model predicts each cycle's outputs.
module tb_hilo_unit;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic        ex_done;
    logic [63:0] ex_result;
    logic [31:0] ex_src;
    logic        ex_ready;
    logic        commit;
    logic        flush;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        rd_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  pend_cnt;

`ifdef HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    hilo_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_op     (ex_op),
        .ex_done   (ex_done),
        .ex_result (ex_result),
        .ex_src    (ex_src),
        .ex_ready  (ex_ready),
        .commit    (commit),
        .flush     (flush),
        .rd_req    (rd_req),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_stall  (rd_stall),
        .hi        (hi),
        .lo        (lo),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] rd_data;
        logic [1:0]  cnt;
        logic        ready;
        logic        stall;
        logic        rd_req;
    } exp_t;

    typedef struct {
        bit          we_hi;
        bit          we_lo;
        logic [31:0] hv;
        logic [31:0] lv;
    } ent_t;

    exp_t        exp_q[$];
    ent_t        pend[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, want, $time);
        end
    endtask

    // Predict this cycle's outputs from the pre-edge model, then advance the model across the edge.
    task automatic model_step(input bit cmp);
        exp_t        e;
        ent_t        n;
        ent_t        h;
        bit          found;
        bit          do_push;
        logic [31:0] fv;
        found = 1'b0;
        fv    = 32'd0;
        e.cnt    = 2'(pend.size());
        e.ready  = (pend.size() < 2) || commit;
        e.hi     = m_hi;
        e.lo     = m_lo;
        e.rd_req = rd_req;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (!found && (rd_sel ? pend[i].we_hi : pend[i].we_lo)) begin
                found = 1'b1;
                fv = rd_sel ? pend[i].hv : pend[i].lv;
            end
        end
        e.rd_data = (BYP && found) ? fv : (rd_sel ? m_hi : m_lo);
        e.stall   = rd_req && found && !BYP;
        if (cmp) exp_q.push_back(e);

        if (reset) begin
            pend.delete();
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            do_push = ex_valid && e.ready && !flush &&
                      (ex_op == 2'd1 || ex_op == 2'd2 || (ex_op == 2'd3 && ex_done));
            n.we_hi = (ex_op == 2'd2) || (ex_op == 2'd3);
            n.we_lo = (ex_op == 2'd1) || (ex_op == 2'd3);
            n.hv    = (ex_op == 2'd3) ? ex_result[63:32] : ex_src;
            n.lv    = (ex_op == 2'd3) ? ex_result[31:0] : ex_src;
            if (commit && pend.size() > 0) begin
                h = pend.pop_front();
                if (h.we_hi) m_hi = h.hv;
                if (h.we_lo) m_lo = h.lv;
            end
            if (flush) pend.delete();
            else if (do_push) pend.push_back(n);
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] op, input logic d, input logic [63:0] res,
                       input logic [31:0] src, input logic c, input logic f, input logic rq,
                       input logic rs, input logic rst, input bit cmp);
        @(posedge clk);
        #1;
        ex_valid  = v;
        ex_op     = op;
        ex_done   = d;
        ex_result = res;
        ex_src    = src;
        commit    = c;
        flush     = f;
        rd_req    = rq;
        rd_sel    = rs;
        reset     = rst;
        model_step(cmp);
    endtask

    task automatic idle(input logic c, input logic rq, input logic rs);
        cyc(1'b0, 2'd0, 1'b0, 64'd0, 32'd0, c, 1'b0, rq, rs, 1'b0, 1'b1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pend_cnt", {30'd0, pend_cnt}, {30'd0, e.cnt});
                chk("ex_ready", {31'd0, ex_ready}, {31'd0, e.ready});
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("rd_stall", {31'd0, rd_stall}, {31'd0, e.stall});
                if (e.rd_req) chk("rd_data", rd_data, e.rd_data);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        ex_valid = 1'b0; ex_op = 2'd0; ex_done = 1'b0; ex_result = 64'd0; ex_src = 32'd0;
        commit = 1'b0; flush = 1'b0; rd_req = 1'b0; rd_sel = 1'b0; reset = 1'b1;

        repeat (2) cyc(1'b0, 2'd0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b1, 1'b1);

        // MULDIV push then commit
        cyc(1'b1, 2'd3, 1'b1, 64'h11112222_33334444, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b1, 1'b1);

        // MT_HI, MT_LO, reads of both halves with nothing committed
        cyc(1'b1, 2'd2, 1'b0, 64'd0, 32'hAAAA0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 2'd1, 1'b0, 64'd0, 32'h00005555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b1, 1'b1);
        idle(1'b0, 1'b1, 1'b0);

        // Full buffer: blocked push, then push alongside commit, then drain
        cyc(1'b1, 2'd3, 1'b1, 64'hDEADBEEF_CAFEF00D, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 1'b0, 64'd0, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) idle(1'b1, 1'b1, 1'b0);

        // Two pending, flush together with commit
        cyc(1'b1, 2'd2, 1'b0, 64'd0, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 2'd1, 1'b0, 64'd0, 32'h0000BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 2'd3, 1'b1, 64'h99998888_77776666, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b1, 1'b1);
        idle(1'b0, 1'b1, 1'b0);

        // MULDIV waiting on ex_done
        repeat (5) cyc(1'b1, 2'd3, 1'b0, 64'h55554444_33332222, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 2'd3, 1'b1, 64'h55554444_33332222, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 1'b1, 1'b1);
        idle(1'b0, 1'b1, 1'b0);

        // Pending MT_LO read until commit
        cyc(1'b1, 2'd1, 1'b0, 64'd0, 32'hFACE0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) idle(1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        idle(1'b0, 1'b1, 1'b0);

        // Reset dominating commit, flush and push
        cyc(1'b1, 2'd3, 1'b1, 64'h01234567_89ABCDEF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 1'b0, 64'd0, 32'h77777777, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b0, 1'b1, 1'b1);

        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 3) == 0,
                {$urandom, $urandom}, $urandom, ($urandom % 3) == 0, ($urandom % 20) == 0,
                1'($urandom % 2), 1'($urandom % 2), ($urandom % 200) == 0, 1'b1);
        end
        idle(1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 clk  in  1  clock; all state updates on posedge clk.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 ex_valid  in  1  EX stage holds a HI/LO-writing instruction.
REQ-004 ex_op  in  2  write kind: 0=none, 1=MT_LO (lo only), 2=MT_HI (hi only), 3=MULDIV (both).
REQ-005 ex_done  in  1  ALU result valid this cycle (mul_data_ok or divider dout valid); ignored unless ex_op==3.
REQ-006 ex_result  in  64  ALU mul/div result; [63:32] to HI, [31:0] to LO.
REQ-007 ex_src  in  32  rs value for MT_HI/MT_LO.
REQ-008 ex_ready  out  1  pending buffer can accept a push this cycle.
REQ-009 commit  in  1  oldest pending write retires to architectural HI/LO.
REQ-010 flush  in  1  exception/eret cancel; discards all pending writes.
REQ-011 rd_req  in  1  MFHI/MFLO read request.
REQ-012 rd_sel  in  1  0=LO, 1=HI.
REQ-013 rd_data  out  32  read value, combinational.
REQ-014 rd_stall  out  1  read cannot be satisfied this cycle.
REQ-015 hi, lo  out  32 each  architectural registers.
REQ-016 pend_cnt  out  2  number of pending entries (0..2).

Function
REQ-017 Pending buffer SHALL be a 2-entry in-order FIFO; entry = {we_hi, we_lo, hi_val, lo_val}.
REQ-018 Push SHALL occur when ex_valid & ex_ready & !flush & (ex_op==1|2 | (ex_op==3 & ex_done)).
REQ-019 MT_HI entry SHALL be {1,0,ex_src,x}; MT_LO {0,1,x,ex_src}; MULDIV {1,1,ex_result[63:32],ex_result[31:0]}.
REQ-020 ex_ready SHALL be 1 when pend_cnt<2, or pend_cnt==2 and commit asserted (push+pop same cycle).
REQ-021 On commit with pend_cnt>0, arch HI/LO SHALL update from the head entry per its we bits, one cycle latency; head pops.
REQ-022 Commit with pend_cnt==0 SHALL be ignored, no state change.
REQ-023 flush SHALL clear all pending entries next cycle; a commit in the same cycle SHALL still retire the head first; a same-cycle push SHALL be dropped.
REQ-024 rd_data SHALL return the selected half from the youngest pending entry whose matching we bit is set, else arch register.
REQ-025 rd_stall SHALL be 0 when HILO_BYPASS_EN is defined; see REQ-030.
REQ-026 A read and a commit in the same cycle SHALL yield the pre-commit forwarded value (identical value by REQ-024).
REQ-027 Pointers SHALL wrap modulo 2; pend_cnt SHALL never exceed 2 or underflow.

Reset
REQ-028 On reset: hi=0, lo=0, pend_cnt=0, all entries invalid, ex_ready=1, rd_stall=0, rd_data=0 (arch value).
REQ-029 Reset SHALL override commit, flush and push in the same cycle.

Configuration
REQ-030 Macro HILO_BYPASS_EN: defined -> forwarding per REQ-024; undefined -> rd_data reads arch only, rd_stall = rd_req & any pending entry writes the selected half.

Structure
REQ-031 Shared package SHALL hold ex_op encodings (HILO_OP_NONE/MTLO/MTHI/MULDIV) and pending-entry width constant.
REQ-032 One sub-module hilo_pend_fifo (2-entry FIFO with per-entry lookup of youngest hi/lo writer) is natural; rest is arch regs and read mux.

Verification
REQ-033 MULDIV push ex_result=64'h11112222_33334444, commit next cycle -> hi=32'h11112222, lo=32'h33334444, pend_cnt 1->0.
REQ-034 MT_HI 0xAAAA0000 then MT_LO 0x5555, no commit, rd_sel=1 then 0 -> rd_data 0xAAAA0000 then 0x5555 (bypass), hi/lo unchanged.
REQ-035 Fill 2 entries -> ex_ready=0; push+commit same cycle -> accepted, pend_cnt stays 2.
REQ-036 Two pending entries, flush with commit -> head retires, second discarded, pend_cnt=0.
REQ-037 ex_op=3 with ex_done=0 for 5 cycles -> no push; ex_done=1 -> single push.
REQ-038 Build without HILO_BYPASS_EN, pending MT_LO, rd_req rd_sel=0 -> rd_stall=1 until commit, then rd_data=new lo.
